acc_drain: RTL and testbench

Output drain stage for one row of the output-stationary systolic array. It sits directly downstream of the PE row and snapshots all N PE accumulators on a capture pulse. It then pulses a clear back to the PEs, and streams the snapshotted values out one per handshake. Each value is requantized to OUT_W bits by a signed arithmetic right shift with saturation.

---
 rtl/acc_drain_if.sv | 30 +++
 rtl/acc_drain.sv | 115 +++++++++++
 tb/tb_acc_drain.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_drain_if.sv
// Output stream of the accumulator drain stage: one requantized lane word per
// valid/ready handshake, tagged with its lane index and a last-lane flag.
interface acc_drain_if #(
   parameter int N     = 4,
   parameter int OUT_W = 16
);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_idx,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_idx,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/acc_drain.sv
// Drain stage for one systolic-array row: snapshots N PE accumulators on capture,
// pulses a clear back to the PEs, then streams the lanes out requantized to OUT_W.
module acc_drain #(
   parameter int N     = 4,
   parameter int ACC_W = 32,
   parameter int OUT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*ACC_W-1:0] acc_in,
   input  logic               capture,
   input  logic [4:0]         shift,
   output logic               acc_clear,
   output logic               busy,
   output logic               capture_drop,
   acc_drain_if.master        out_if
);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
   localparam logic [OUT_W-1:0] SAT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] SAT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t                   state_reg, state_next;
   logic [IDX_W-1:0]         idx_reg, idx_next;
   logic [4:0]               shift_reg;
   logic                     acc_clear_reg, capture_drop_reg;
   logic                     drop_next;
   logic                     transfer, final_xfer, accept;
   logic signed [ACC_W-1:0]  shadow_reg [N];
   logic signed [ACC_W-1:0]  sel_val, shifted;
   logic [OUT_W-1:0]         quant_data;
   logic                     fits;

   // Acceptance happens in IDLE, or exactly on the last-lane transfer so
   // consecutive snapshots stream without a bubble.
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      transfer   = (state_reg == DRAIN) && out_if.out_ready;
      final_xfer = transfer && (idx_reg == LAST_IDX);
      accept     = capture && ((state_reg == IDLE) || final_xfer);
      drop_next  = capture && !accept;
      if (accept) begin
         state_next = DRAIN;
         idx_next   = '0;
      end else if (final_xfer) begin
         state_next = IDLE;
         idx_next   = '0;
      end else if (transfer) begin
         idx_next   = idx_reg + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= IDLE;
         idx_reg          <= '0;
         shift_reg        <= '0;
         acc_clear_reg    <= 1'b0;
         capture_drop_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         idx_reg          <= idx_next;
         acc_clear_reg    <= accept;
         capture_drop_reg <= drop_next;
         if (accept) begin
            shift_reg <= shift;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            shadow_reg[i] <= '0;
         end
      end else if (accept) begin
         for (int i = 0; i < N; i++) begin
            shadow_reg[i] <= acc_in[i*ACC_W +: ACC_W];
         end
      end
   end

   // Floor shift then saturate: the value fits when every bit above the
   // output sign bit agrees with it.
   always_comb begin
      sel_val = shadow_reg[idx_reg];
      if (int'(shift_reg) >= ACC_W - 1) begin
         shifted = sel_val[ACC_W-1] ? '1 : '0;
      end else begin
         shifted = sel_val >>> shift_reg;
      end
      fits = (&shifted[ACC_W-1:OUT_W-1]) || !(|shifted[ACC_W-1:OUT_W-1]);
      if (fits) begin
         quant_data = shifted[OUT_W-1:0];
      end else if (shifted[ACC_W-1]) begin
         quant_data = SAT_MIN;
      end else begin
         quant_data = SAT_MAX;
      end
   end

   assign busy             = (state_reg == DRAIN);
   assign acc_clear        = acc_clear_reg;
   assign capture_drop     = capture_drop_reg;
   assign out_if.out_valid = (state_reg == DRAIN);
   assign out_if.out_data  = quant_data;
   assign out_if.out_idx   = idx_reg;
   assign out_if.out_last  = (state_reg == DRAIN) && (idx_reg == LAST_IDX);
endmodule

// File: tb/tb_acc_drain.sv
// Randomized and directed bench for acc_drain: a queue-based model of the
// pending output words is compared against the DUT on every falling edge.
module tb_acc_drain;
   localparam int N     = 4;
   localparam int ACC_W = 32;
   localparam int OUT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N*ACC_W-1:0] acc_in;
   logic             capture;
   logic [4:0]       shift;
   logic             acc_clear, busy, capture_drop;

   acc_drain_if #(.N(N), .OUT_W(OUT_W)) dif ();

   acc_drain #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .acc_in       (acc_in),
      .capture      (capture),
      .shift        (shift),
      .acc_clear    (acc_clear),
      .busy         (busy),
      .capture_drop (capture_drop),
      .out_if       (dif.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      int          idx;
   } word_t;

   word_t       exp_q[$];
   bit          exp_clear, exp_drop;
   logic [15:0] log_q[$];
   int          clear_cnt, drop_cnt, valid_cnt;
   int          n_total, n_pass;
   bit          prev_stall;
   logic [15:0] prev_data;
   logic [1:0]  prev_idx;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Requantization from first principles: floor division by 2^sh, then clamp.
   function automatic logic [15:0] model_q(logic [31:0] raw, int sh);
      longint v, d, r;
      v = longint'($signed(raw));
      d = longint'(1) << sh;
      r = v / d;
      if (v < 0 && (v % d) != 0) r = r - 1;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return 16'(r);
   endfunction

   // Model: the queue holds the words still owed by the current drain.
   initial begin
      int  pend;
      bit  xfer, acc;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            exp_q.delete();
            exp_clear = 1'b0;
            exp_drop  = 1'b0;
         end else begin
            pend = exp_q.size();
            xfer = (pend > 0) && dif.out_ready;
            acc  = capture && (pend == 0 || (pend == 1 && xfer));
            exp_clear = acc;
            exp_drop  = capture && !acc;
            if (xfer) void'(exp_q.pop_front());
            if (acc) begin
               for (int i = 0; i < N; i++) begin
                  exp_q.push_back('{data: model_q(acc_in[i*ACC_W +: ACC_W], int'(shift)), idx: i});
               end
            end
         end
      end
   end

   initial begin
      bit ev;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("reset_outs", {dif.out_valid, busy, acc_clear, capture_drop, dif.out_last,
                               dif.out_idx, dif.out_data}, 32'h0);
            prev_stall = 1'b0;
         end else begin
            ev = exp_q.size() > 0;
            chk("out_valid", 32'(dif.out_valid), 32'(ev));
            chk("busy", 32'(busy), 32'(ev));
            chk("acc_clear", 32'(acc_clear), 32'(exp_clear));
            chk("capture_drop", 32'(capture_drop), 32'(exp_drop));
            if (ev) begin
               chk("out_data", 32'(dif.out_data), 32'(exp_q[0].data));
               chk("out_idx", 32'(dif.out_idx), 32'(exp_q[0].idx));
               chk("out_last", 32'(dif.out_last), 32'(exp_q[0].idx == N - 1));
            end
            if (prev_stall) begin
               chk("hold_data", 32'(dif.out_data), 32'(prev_data));
               chk("hold_idx", 32'(dif.out_idx), 32'(prev_idx));
            end
            if (dif.out_valid && dif.out_ready) log_q.push_back(dif.out_data);
            if (acc_clear) clear_cnt++;
            if (capture_drop) drop_cnt++;
            if (dif.out_valid) valid_cnt++;
            prev_stall = dif.out_valid && !dif.out_ready;
            prev_data  = dif.out_data;
            prev_idx   = dif.out_idx;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_log(string nm, logic [63:0] exp_words, int exp_clears);
      chk({nm, "_count"}, 32'(log_q.size()), 32'(N));
      for (int i = 0; i < N; i++) begin
         if (i < log_q.size())
            chk($sformatf("%s_w%0d", nm, i), 32'(log_q[i]), 32'(exp_words[i*16 +: 16]));
      end
      chk({nm, "_clears"}, 32'(clear_cnt), 32'(exp_clears));
   endtask

   task automatic drain_case(string nm, logic [N*ACC_W-1:0] lanes, logic [4:0] sh,
                             logic [63:0] exp_words);
      log_q.delete();
      clear_cnt   = 0;
      acc_in      = lanes;
      shift       = sh;
      dif.out_ready = 1'b1;
      capture     = 1'b1;
      tick();
      capture     = 1'b0;
      acc_in      = {$urandom, $urandom, $urandom, $urandom};
      shift       = 5'($urandom_range(0, 31));
      repeat (8) tick();
      check_log(nm, exp_words, 1);
   endtask

   localparam logic [N*ACC_W-1:0] LANES = {32'h80000000, 32'h7FFFFFFF, 32'hFFFFFF00, 32'h00001234};
   localparam logic [63:0] EXP_S0  = {16'h8000, 16'h7FFF, 16'hFF00, 16'h1234};
   localparam logic [63:0] EXP_S4  = {16'h8000, 16'h7FFF, 16'hFFF0, 16'h0123};
   localparam logic [63:0] EXP_S31 = {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};

   initial begin
      logic [6:0] pat;
      n_total = 0;
      n_pass  = 0;
      rst_n   = 1'b0;
      capture = 1'b0;
      shift   = '0;
      acc_in  = '0;
      dif.out_ready = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();

      drain_case("shift0", LANES, 5'd0, EXP_S0);
      drain_case("shift4", LANES, 5'd4, EXP_S4);
      drain_case("shift31", LANES, 5'd31, EXP_S31);

      // Backpressure: ready pattern 1,0,0,1,1,0,1 (first entry in the LSB).
      log_q.delete();
      clear_cnt = 0;
      pat       = 7'b1011001;
      acc_in    = LANES;
      shift     = 5'd0;
      capture   = 1'b1;
      tick();
      capture   = 1'b0;
      for (int i = 0; i < 7; i++) begin
         dif.out_ready = pat[i];
         tick();
      end
      dif.out_ready = 1'b1;
      repeat (4) tick();
      check_log("bp", EXP_S0, 1);

      // Capture held across two drains: drops on non-final cycles, seamless restart.
      log_q.delete();
      clear_cnt = 0;
      drop_cnt  = 0;
      acc_in    = LANES;
      capture   = 1'b1;
      repeat (9) tick();
      capture   = 1'b0;
      repeat (8) tick();
      chk("held_words", 32'(log_q.size()), 32'(3 * N));
      chk("held_clears", 32'(clear_cnt), 32'd3);
      chk("held_drops", 32'(drop_cnt), 32'd6);

      // Asynchronous reset during the second drain cycle.
      capture = 1'b1;
      tick();
      capture = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_outs", {dif.out_valid, busy, acc_clear, capture_drop, dif.out_last,
                             dif.out_idx, dif.out_data}, 32'h0);
      tick();
      tick();
      #2 rst_n = 1'b1;
      clear_cnt = 0;
      valid_cnt = 0;
      repeat (4) tick();
      chk("post_rst_clear", 32'(clear_cnt), 32'd0);
      chk("post_rst_valid", 32'(valid_cnt), 32'd0);
      drain_case("post_rst", LANES, 5'd0, EXP_S0);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         capture       = ($urandom_range(0, 5) == 0);
         dif.out_ready = ($urandom_range(0, 3) != 0);
         shift         = 5'($urandom_range(0, 31));
         for (int l = 0; l < N; l++) begin
            if ($urandom_range(0, 1) == 0) acc_in[l*ACC_W +: ACC_W] = $urandom;
            else acc_in[l*ACC_W +: ACC_W] = 32'($urandom_range(0, 131071)) - 32'd65536;
         end
         tick();
      end
      capture       = 1'b0;
      dif.out_ready = 1'b1;
      repeat (10) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
